modbus_rx_framer: RTL and testbench
===================================

# modbus_rx_framer

- Receives the Modbus RTU request byte stream from the UART receiver.
- Delimits frames by inter-character silence and checks the CRC-16 over each complete 8-byte request.
- Delivers each valid request as a single 64-bit word with a one-cycle strobe to the downstream register data processor (`frame_data` → `datain`, `frame_valid` → `Enable`).
- Sits between the UART byte receiver and the data processor in the communication path.

## Interface
Parameters:
- `T35_CYCLES`, 3500: silence length in clk cycles that terminates a frame (3.5 character times); minimum 2.
- `SLAVE_ADDR`, 8'h01: own slave address; 8'h00 (broadcast) is always accepted.

Ports:
- `clk` input 1: system clock; all logic on posedge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `rx_data` input 8: received byte, valid when `rx_valid`=1.
- `rx_valid` input 1: one-cycle byte strobe from the UART.
- `rx_err` input 1: UART framing/parity error strobe.
- `frame_data` output 64: delivered frame; byte i at bits [8i+7:8i], i=0..7, in received order. Byte 0 = address, byte 1 = function, bytes 6/7 = CRC lo/hi.
- `frame_valid` output 1: one-cycle strobe; `frame_data` is valid from this cycle and held until the next delivery.
- `crc_err` output 1: one-cycle strobe; an 8-byte frame failed the CRC check.
- `frame_err` output 1: one-cycle strobe; length error, overflow, or `rx_err` during a frame.
- `err_cnt` output 8: saturating count of `crc_err` and `frame_err` events; saturates at 8'hFF.
- `busy` output 1: high while a frame is in progress (state ≠ IDLE).

## Operation
- Reset values: `frame_data`=0, `err_cnt`=0; `frame_valid`, `crc_err`, `frame_err`, `busy` all 0. FSM enters IDLE, CRC=16'hFFFF, byte count=0, gap counter=0.
- **Assembly:** accepted bytes fill an internal 64-bit shift buffer. `frame_data` updates only on delivery.
- **CRC:** CRC-16/Modbus (reflected poly 16'hA001, init 16'hFFFF), updated over all 8 bits of one byte per `rx_valid` cycle. The CRC is run over all 8 bytes, including the received CRC bytes; a result of 16'h0000 means the CRC is good.
- **Gap counter:** cleared on every `rx_valid`; otherwise increments while not in IDLE. Reaching `T35_CYCLES`-1 is the "gap" event.
- **FSM:**
  - IDLE: on `rx_valid`, store byte 0 (CRC initialised, then updated with it), count=1, go to RECV.
  - RECV: on `rx_valid` with count<8, store the byte and count++. On `rx_valid` with count==8, go to OVERFLOW. On `rx_err`, go to OVERFLOW. On gap, evaluate and go to IDLE.
  - OVERFLOW: discard bytes. On gap, pulse `frame_err` and go to IDLE.
- **Evaluate at gap (RECV):**
  - count≠8: `frame_err`.
  - count==8 and CRC≠0: `crc_err`.
  - count==8, CRC==0, address not accepted: silent drop.
  - Otherwise: copy buffer to `frame_data` and pulse `frame_valid`.
- **Simultaneous events:**
  - `rx_valid` in the gap cycle: the byte wins; it belongs to the current frame and the counter clears.
  - `rx_err` together with `rx_valid`: the byte is discarded and the FSM goes to OVERFLOW.
  - `rx_err` in IDLE: ignored.
- **Reset mid-frame:** the partial frame is lost; no strobe is issued.
- **Error counting:** `err_cnt` increments once per `crc_err`/`frame_err` pulse.

## Timing
- One byte is accepted per `rx_valid` cycle; back-to-back `rx_valid` is supported.
- `frame_valid` / `crc_err` / `frame_err` go high on the clock edge `T35_CYCLES`+1 cycles after the edge that sampled the last `rx_valid`, and stay high exactly one cycle.
- A new frame's first byte can be accepted in the cycle the strobe is high; `frame_data` stays unchanged until that frame's delivery.
- At most one of the three strobes is high in any cycle.

## Configuration
- `MODBUS_ADDR_FILTER_EN` defined: only frames with byte 0 == `SLAVE_ADDR` or 8'h00 are delivered; others are dropped silently (no strobe, no count).
- Undefined: every CRC-good 8-byte frame is delivered regardless of address.

## Test plan
- `T35_CYCLES`=8. Bytes 01 03 00 00 00 0A C5 CD back-to-back → one `frame_valid` 9 cycles after the last byte, `frame_data`=64'hCDC5_0A00_0000_0301, `err_cnt`=0.
- Same frame with last byte CD changed to CE → `crc_err` pulse, `frame_data` unchanged, `err_cnt`=1.
- 5 bytes then silence → `frame_err`. Next, 9 bytes → `frame_err`, no `frame_valid`, `err_cnt` +1 each.
- `rx_err` after byte 3, remaining bytes still sent → single `frame_err` after the gap. A subsequent good frame is delivered.
- With the macro defined, a frame with address 02 and valid CRC → no strobe. The same frame with the macro undefined → `frame_valid`.
- Assert `rst_n` low after byte 4 of a good frame, then release → no strobe, all outputs at reset values, next good frame delivered normally.

Source files
------------

// File: rtl/modbus_rx_framer.sv
`timescale 1ns/1ps
// modbus_rx_framer: Modbus RTU request framer.
// Delimits frames by inter-character silence, checks CRC-16/Modbus over
// 8-byte requests and delivers good frames as one 64-bit word with a strobe.
// Optional feature: define MODBUS_ADDR_FILTER_EN to deliver only frames
// addressed to SLAVE_ADDR or broadcast (8'h00).
module modbus_rx_framer #(
  parameter int unsigned T35_CYCLES = 3500,
  parameter logic [7:0]  SLAVE_ADDR = 8'h01
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_err,
  output logic [63:0] frame_data,
  output logic        frame_valid,
  output logic        crc_err,
  output logic        frame_err,
  output logic [7:0]  err_cnt,
  output logic        busy
);

  localparam int unsigned GW = $clog2(T35_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(T35_CYCLES - 1);
  localparam logic [GW-1:0] GAP_MAX  = GW'(T35_CYCLES);

  typedef enum logic [1:0] {IDLE, RECV, OVERFLOW} state_t;

  state_t        state, state_nxt;
  logic [63:0]   shift_q;
  logic [15:0]   crc_q;
  logic [3:0]    cnt_q;
  logic [GW-1:0] gap_cnt;
  logic          gap_q;
  logic          take_byte;
  logic          addr_match;
  logic          addr_ok;
  logic          fv_nxt, ce_nxt, fe_nxt;

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {8'h00, d};
    for (int unsigned i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    end
    return r;
  endfunction

  assign take_byte  = rx_valid && !rx_err;
  assign busy       = (state != IDLE);
  assign addr_match = (shift_q[7:0] == SLAVE_ADDR) || (shift_q[7:0] == 8'h00);

`ifdef MODBUS_ADDR_FILTER_EN
  assign addr_ok = addr_match;
`else
  // Address is decoded but never blocks delivery in this build.
  assign addr_ok = addr_match | 1'b1;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; a byte arriving in the gap cycle takes priority over the gap
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (rx_valid) state_nxt = rx_err ? OVERFLOW : RECV;
      end
      RECV: begin
        if (rx_err)                      state_nxt = OVERFLOW;
        else if (rx_valid)               state_nxt = (cnt_q == 4'd8) ? OVERFLOW : RECV;
        else if (gap_q)                  state_nxt = IDLE;
      end
      OVERFLOW: begin
        if (gap_q && !rx_valid)          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Strobe decode: frame evaluation happens on the gap cycle
  always_comb begin
    fv_nxt = 1'b0;
    ce_nxt = 1'b0;
    fe_nxt = 1'b0;
    if (state == RECV && gap_q && !rx_valid && !rx_err) begin
      if (cnt_q != 4'd8)        fe_nxt = 1'b1;
      else if (crc_q != 16'h0)  ce_nxt = 1'b1;
      else if (addr_ok)         fv_nxt = 1'b1;
    end else if (state == OVERFLOW && gap_q && !rx_valid) begin
      fe_nxt = 1'b1;
    end
  end

  // Byte assembly and running CRC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      crc_q   <= '1;
      cnt_q   <= '0;
    end else if (take_byte && state == IDLE) begin
      shift_q <= {rx_data, shift_q[63:8]};
      crc_q   <= crc_byte(16'hFFFF, rx_data);
      cnt_q   <= 4'd1;
    end else if (take_byte && state == RECV && cnt_q != 4'd8) begin
      shift_q <= {rx_data, shift_q[63:8]};
      crc_q   <= crc_byte(crc_q, rx_data);
      cnt_q   <= cnt_q + 4'd1;
    end
  end

  // Silence counter; the gap event is registered so evaluation lands
  // T35_CYCLES+1 edges after the last sampled byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt <= '0;
      gap_q   <= 1'b0;
    end else begin
      if (rx_valid)                           gap_cnt <= '0;
      else if (state != IDLE && gap_cnt != GAP_MAX) gap_cnt <= gap_cnt + 1'b1;
      gap_q <= (state != IDLE) && !rx_valid && (gap_cnt == GAP_LAST);
    end
  end

  // Registered outputs: strobes, delivered word, saturating error count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_data  <= '0;
      frame_valid <= 1'b0;
      crc_err     <= 1'b0;
      frame_err   <= 1'b0;
      err_cnt     <= '0;
    end else begin
      frame_valid <= fv_nxt;
      crc_err     <= ce_nxt;
      frame_err   <= fe_nxt;
      if (fv_nxt) frame_data <= shift_q;
      if ((ce_nxt || fe_nxt) && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_modbus_rx_framer.sv
`timescale 1ns/1ps
// Directed bench for modbus_rx_framer with T35_CYCLES=8.
module tb_modbus_rx_framer;

  localparam int unsigned T35 = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_err = 1'b0;
  logic [63:0] frame_data;
  logic        frame_valid, crc_err, frame_err, busy;
  logic [7:0]  err_cnt;

  int total = 0;
  int bad = 0;

  logic [7:0] tx [0:15];
  int fv_n, fv_at, ce_n, ce_at, fe_n, fe_at, multi;

  localparam logic [63:0] GOOD_A = 64'hCDC5_0A00_0000_0301;
  logic [63:0] good_b, addr2;

  modbus_rx_framer #(.T35_CYCLES(T35), .SLAVE_ADDR(8'h01)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
    .frame_data(frame_data), .frame_valid(frame_valid), .crc_err(crc_err),
    .frame_err(frame_err), .err_cnt(err_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mk_frame(input logic [47:0] body);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < 6; i++) begin
      c = c ^ {8'h00, body[8*i +: 8]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return {c[15:8], c[7:0], body};
  endfunction

  task automatic load(input logic [63:0] w);
    for (int i = 0; i < 8; i++) tx[i] = w[8*i +: 8];
  endtask

  // Sends n bytes back to back; err_slot>=0 inserts one rx_err-only cycle before that byte.
  // Returns at the negedge following the edge that sampled the last byte.
  task automatic send(input int n, input int err_slot);
    for (int i = 0; i < n; i++) begin
      if (i == err_slot) begin
        @(negedge clk); rx_valid = 1'b0; rx_err = 1'b1;
      end
      @(negedge clk); rx_valid = 1'b1; rx_err = 1'b0; rx_data = tx[i];
    end
    @(negedge clk); rx_valid = 1'b0; rx_err = 1'b0;
  endtask

  task automatic watch(input int cycles);
    fv_n = 0; fv_at = 0; ce_n = 0; ce_at = 0; fe_n = 0; fe_at = 0; multi = 0;
    for (int k = 1; k <= cycles; k++) begin
      @(negedge clk);
      if (frame_valid) begin fv_n++; fv_at = k; end
      if (crc_err)     begin ce_n++; ce_at = k; end
      if (frame_err)   begin fe_n++; fe_at = k; end
      if (int'(frame_valid) + int'(crc_err) + int'(frame_err) > 1) multi++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (frame_data !== 64'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", frame_data); end
    total++; if ({frame_valid, crc_err, frame_err, busy} !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {frame_valid, crc_err, frame_err, busy}); end
    total++; if (err_cnt !== 8'h00) begin bad++; $display("FAIL reset_errcnt got=%0d exp=0", err_cnt); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_good_frame();
    load(GOOD_A);
    send(8, -1);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL good_busy got=%b exp=1", busy); end
    watch(14);
    total++; if (fv_n !== 1 || fv_at !== T35 + 1) begin bad++; $display("FAIL good_valid got n=%0d at=%0d exp n=1 at=%0d", fv_n, fv_at, T35 + 1); end
    total++; if (ce_n + fe_n + multi !== 0) begin bad++; $display("FAIL good_noerr got ce=%0d fe=%0d exp 0", ce_n, fe_n); end
    total++; if (frame_data !== GOOD_A) begin bad++; $display("FAIL good_data got=%h exp=%h", frame_data, GOOD_A); end
    total++; if (err_cnt !== 8'd0 || busy !== 1'b0) begin bad++; $display("FAIL good_cnt got cnt=%0d busy=%b exp 0/0", err_cnt, busy); end
  endtask

  task automatic test_crc_error();
    load(GOOD_A);
    tx[7] = 8'hCE;
    send(8, -1);
    watch(14);
    total++; if (ce_n !== 1 || ce_at !== T35 + 1 || fv_n !== 0 || fe_n !== 0) begin bad++; $display("FAIL crc_strobe got ce=%0d at=%0d fv=%0d fe=%0d exp 1/%0d/0/0", ce_n, ce_at, fv_n, fe_n, T35 + 1); end
    total++; if (frame_data !== GOOD_A) begin bad++; $display("FAIL crc_data got=%h exp=%h", frame_data, GOOD_A); end
    total++; if (err_cnt !== 8'd1) begin bad++; $display("FAIL crc_cnt got=%0d exp=1", err_cnt); end
  endtask

  task automatic test_length();
    load(GOOD_A);
    send(5, -1);
    watch(14);
    total++; if (fe_n !== 1 || fe_at !== T35 + 1 || fv_n !== 0 || ce_n !== 0) begin bad++; $display("FAIL short_strobe got fe=%0d at=%0d fv=%0d ce=%0d exp 1/%0d/0/0", fe_n, fe_at, fv_n, ce_n, T35 + 1); end
    total++; if (err_cnt !== 8'd2) begin bad++; $display("FAIL short_cnt got=%0d exp=2", err_cnt); end
    load(GOOD_A);
    tx[8] = 8'h55;
    send(9, -1);
    watch(14);
    total++; if (fe_n !== 1 || fe_at !== T35 + 1 || fv_n !== 0 || ce_n !== 0) begin bad++; $display("FAIL long_strobe got fe=%0d at=%0d fv=%0d ce=%0d exp 1/%0d/0/0", fe_n, fe_at, fv_n, ce_n, T35 + 1); end
    total++; if (err_cnt !== 8'd3) begin bad++; $display("FAIL long_cnt got=%0d exp=3", err_cnt); end
  endtask

  task automatic test_rx_err();
    load(GOOD_A);
    send(8, 3);
    watch(14);
    total++; if (fe_n !== 1 || fv_n !== 0 || ce_n !== 0 || multi !== 0) begin bad++; $display("FAIL rxerr_strobe got fe=%0d fv=%0d ce=%0d exp 1/0/0", fe_n, fv_n, ce_n); end
    total++; if (err_cnt !== 8'd4) begin bad++; $display("FAIL rxerr_cnt got=%0d exp=4", err_cnt); end
    load(good_b);
    send(8, -1);
    watch(14);
    total++; if (fv_n !== 1 || frame_data !== good_b) begin bad++; $display("FAIL rxerr_recover got n=%0d data=%h exp 1/%h", fv_n, frame_data, good_b); end
  endtask

  task automatic test_addr_filter();
    load(addr2);
    send(8, -1);
    watch(14);
`ifdef MODBUS_ADDR_FILTER_EN
    total++; if (fv_n + ce_n + fe_n !== 0 || frame_data !== good_b) begin bad++; $display("FAIL addr_drop got fv=%0d ce=%0d fe=%0d data=%h exp none", fv_n, ce_n, fe_n, frame_data); end
`else
    total++; if (fv_n !== 1 || frame_data !== addr2) begin bad++; $display("FAIL addr_deliver got n=%0d data=%h exp 1/%h", fv_n, frame_data, addr2); end
`endif
    total++; if (err_cnt !== 8'd4) begin bad++; $display("FAIL addr_cnt got=%0d exp=4", err_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    load(GOOD_A);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); rx_valid = 1'b1; rx_data = tx[i];
    end
    @(negedge clk); rx_valid = 1'b0; rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    watch(14);
    total++; if (fv_n + ce_n + fe_n !== 0) begin bad++; $display("FAIL midrst_strobe got fv=%0d ce=%0d fe=%0d exp 0", fv_n, ce_n, fe_n); end
    total++; if (frame_data !== 64'h0 || err_cnt !== 8'd0 || busy !== 1'b0) begin bad++; $display("FAIL midrst_state got data=%h cnt=%0d busy=%b exp 0/0/0", frame_data, err_cnt, busy); end
    load(GOOD_A);
    send(8, -1);
    watch(14);
    total++; if (fv_n !== 1 || fv_at !== T35 + 1 || frame_data !== GOOD_A) begin bad++; $display("FAIL midrst_next got n=%0d at=%0d data=%h exp 1/%0d/%h", fv_n, fv_at, frame_data, T35 + 1, GOOD_A); end
  endtask

  task automatic test_back_to_back();
    int early;
    early = 0;
    load(GOOD_A);
    tx[0] = 8'h00; // broadcast variant needs its own CRC
    load(mk_frame(48'h0A00_0000_0300));
    send(8, -1);
    for (int k = 1; k < T35 + 1; k++) begin
      @(negedge clk);
      if (frame_valid | crc_err | frame_err) early++;
    end
    @(negedge clk);
    total++; if (early !== 0 || frame_valid !== 1'b1 || frame_data !== mk_frame(48'h0A00_0000_0300)) begin bad++; $display("FAIL b2b_first got early=%0d fv=%b data=%h", early, frame_valid, frame_data); end
    // first byte of the next frame is driven during the strobe cycle
    load(good_b);
    rx_valid = 1'b1; rx_data = tx[0];
    for (int i = 1; i < 8; i++) begin
      @(negedge clk); rx_data = tx[i];
      if (frame_valid | (frame_data !== mk_frame(48'h0A00_0000_0300))) early++;
    end
    @(negedge clk); rx_valid = 1'b0;
    total++; if (early !== 0) begin bad++; $display("FAIL b2b_hold got disturbances=%0d exp=0", early); end
    watch(14);
    total++; if (fv_n !== 1 || fv_at !== T35 + 1 || frame_data !== good_b) begin bad++; $display("FAIL b2b_second got n=%0d at=%0d data=%h exp 1/%0d/%h", fv_n, fv_at, frame_data, T35 + 1, good_b); end
  endtask

  initial begin
    good_b = mk_frame(48'h0300_0100_0601);
    addr2  = mk_frame(48'h0A00_0000_0302);
    test_reset();
    test_good_frame();
    test_crc_error();
    test_length();
    test_rx_err();
    test_addr_filter();
    test_reset_mid_frame();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
